// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use, EX redirect,
// data-memory wait and post-redirect wrong-path squash, plus two perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REDIRECT_EXTRA = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    input  logic             cnt_clear,
    output logic             pc_stall,
    output logic             pc_redirect,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned SQ_W = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        SQUASH   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SQ_W-1:0] squash_q, squash_d;
    logic            load_use;
    logic            redirect;

    // Hazard detection on the ID/EX register pair
    assign load_use = ex_valid & ex_is_load & (ex_rd_addr != 5'd0) & id_valid &
                      ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                       (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
    assign redirect = ex_valid & ex_redirect;

    // State and squash counter registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= RUN;
            squash_q <= '0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
        end
    end

    // Next state and pipeline control; priority mem_busy > redirect > load-use
    always_comb begin
        state_d       = state_q;
        squash_d      = squash_q;
        pc_stall      = 1'b0;
        pc_redirect   = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;

        if (!rst_) begin
            // Pipeline is held empty while in reset
            state_d       = RUN;
            squash_d      = '0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (mem_busy) begin
            // Freeze everything up to MEM; squash count is held
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = MEM_WAIT;
        end else begin
            // Wrong-path squash from an earlier redirect; MEM_WAIT resumes as RUN
            case (state_q)
                SQUASH: begin
                    if_id_flush = 1'b1;
                    squash_d    = (squash_q == '0) ? '0 : squash_q - SQ_W'(1);
                    state_d     = (squash_q <= SQ_W'(1)) ? RUN : SQUASH;
                end
                default: state_d = RUN;
            endcase

            if (redirect) begin
                pc_redirect = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (REDIRECT_EXTRA > 0) begin
                    state_d  = SQUASH;
                    squash_d = SQ_W'(REDIRECT_EXTRA);
                end else begin
                    state_d  = RUN;
                    squash_d = '0;
                end
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Wrapping performance counters with synchronous clear
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (cnt_clear) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall)    stall_cycles <= stall_cycles + CNT_W'(1);
            if (pc_redirect) flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (4-bit counters to reach wrap).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    // Output vector: {pc_stall, pc_redirect, if_id_stall, if_id_flush,
    //                 id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble}
    localparam logic [7:0] O_IDLE = 8'h00;
    localparam logic [7:0] O_RST  = 8'h15;
    localparam logic [7:0] O_LU   = 8'hA4;
    localparam logic [7:0] O_RD   = 8'h54;
    localparam logic [7:0] O_SQ   = 8'h10;
    localparam logic [7:0] O_MB   = 8'hAB;
    localparam logic [7:0] O_SQLU = 8'hB4;

    logic             clk = 1'b0;
    logic             rst_;
    logic             id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic             ex_valid, ex_is_load, ex_redirect, mem_busy, cnt_clear;
    logic             pc_stall, pc_redirect, if_id_stall, if_id_flush;
    logic             id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic [7:0]       outs;

    int n_checks = 0;
    int n_errors = 0;

    assign outs = {pc_stall, pc_redirect, if_id_stall, if_id_flush,
                   id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REDIRECT_EXTRA (1),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .id_valid      (id_valid),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_valid      (ex_valid),
        .ex_is_load    (ex_is_load),
        .ex_rd_addr    (ex_rd_addr),
        .ex_redirect   (ex_redirect),
        .mem_busy      (mem_busy),
        .cnt_clear     (cnt_clear),
        .pc_stall      (pc_stall),
        .pc_redirect   (pc_redirect),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_stall   (id_ex_stall),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_stall  (ex_mem_stall),
        .mem_wb_bubble (mem_wb_bubble),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
        ex_valid = 0; ex_is_load = 0; ex_redirect = 0;
        mem_busy = 0; cnt_clear = 0;
    endtask

    // EX: lw x<rd>; ID: op using rs1/rs2
    task automatic lu_in(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
        ex_valid = 1; ex_is_load = 1; ex_rd_addr = rd;
        id_valid = 1; id_rs1_addr = rs1; id_uses_rs1 = u1;
        id_rs2_addr = rs2; id_uses_rs2 = u2;
    endtask

    // Advance one cycle and land 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_in();
        rst_ = 0;
        #3;
        check("reset_outs", 32'(outs), 32'(O_RST));
        check("reset_stall_cnt", 32'(stall_cycles), 0);
        #9 rst_ = 1;
        cyc();
        check("idle", 32'(outs), 32'(O_IDLE));

        // Load-use on rs1: one bubble
        lu_in(5, 5, 1, 1, 1); #1;
        check("lu_rs1", 32'(outs), 32'(O_LU));
        cyc(); idle_in(); #1;
        check("lu_after", 32'(outs), 32'(O_IDLE));
        check("lu_stall_cnt", 32'(stall_cycles), 1);

        // x0 destination and unused matching register never stall
        lu_in(0, 0, 1, 0, 1); #1;
        check("lu_x0", 32'(outs), 32'(O_IDLE));
        lu_in(5, 5, 0, 1, 1); #1;
        check("lu_unused_rs1", 32'(outs), 32'(O_IDLE));
        lu_in(5, 1, 1, 5, 1); #1;
        check("lu_rs2", 32'(outs), 32'(O_LU));
        cyc(); idle_in(); #1;

        // Redirect with one extra squash cycle
        ex_valid = 1; ex_redirect = 1; #1;
        check("rd_cycle0", 32'(outs), 32'(O_RD));
        cyc(); idle_in(); #1;
        check("rd_cycle1", 32'(outs), 32'(O_SQ));
        cyc(); #1;
        check("rd_cycle2", 32'(outs), 32'(O_IDLE));
        check("rd_flush_cnt", 32'(flush_events), 1);

        // Memory wait for 3 cycles with redirect held in EX
        ex_valid = 1; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1; #1;
            check($sformatf("mw_busy%0d", i), 32'(outs), 32'(O_MB));
            cyc();
        end
        mem_busy = 0; #1;
        check("mw_redirect", 32'(outs), 32'(O_RD));
        cyc(); idle_in(); #1;
        check("mw_squash", 32'(outs), 32'(O_SQ));
        check("mw_stall_cnt", 32'(stall_cycles), 5);
        cyc(); #1;
        check("mw_idle", 32'(outs), 32'(O_IDLE));
        check("mw_flush_cnt", 32'(flush_events), 2);

        // Load-use and redirect together: redirect wins
        lu_in(7, 7, 1, 0, 0); ex_redirect = 1; #1;
        check("lu_rd_same", 32'(outs), 32'(O_RD));
        cyc(); idle_in(); #1;
        check("lu_rd_squash", 32'(outs), 32'(O_SQ));
        cyc(); #1;

        // mem_busy and redirect together: stall only
        ex_valid = 1; ex_redirect = 1; mem_busy = 1; #1;
        check("mb_rd_same", 32'(outs), 32'(O_MB));
        cyc(); idle_in(); #1;
        check("mb_rd_after", 32'(outs), 32'(O_IDLE));
        check("mb_rd_stall_cnt", 32'(stall_cycles), 6);
        check("mb_rd_flush_cnt", 32'(flush_events), 3);

        // Load-use in a squash cycle: both flush and stall act
        ex_valid = 1; ex_redirect = 1; #1;
        cyc(); idle_in(); lu_in(9, 9, 1, 0, 0); #1;
        check("sq_lu", 32'(outs), 32'(O_SQLU));
        cyc(); idle_in(); #1;
        check("sq_lu_after", 32'(outs), 32'(O_IDLE));
        check("sq_lu_stall_cnt", 32'(stall_cycles), 7);

        // Counter wrap: 8 stalls -> 15, one more -> 0
        mem_busy = 1;
        for (int i = 0; i < 8; i++) cyc();
        check("cnt_15", 32'(stall_cycles), 15);
        cyc();
        check("cnt_wrap", 32'(stall_cycles), 0);
        cyc(); cyc();
        check("cnt_2", 32'(stall_cycles), 2);
        cnt_clear = 1;
        cyc(); cnt_clear = 0;
        check("clr_stall", 32'(stall_cycles), 0);
        check("clr_flush", 32'(flush_events), 0);
        idle_in(); #1;
        check("clr_idle", 32'(outs), 32'(O_IDLE));
        cyc();

        // Reset during SQUASH, with mem_busy asserted
        ex_valid = 1; ex_redirect = 1; #1;
        cyc(); idle_in(); mem_busy = 1;
        rst_ = 0; #1;
        check("rst_sq_outs", 32'(outs), 32'(O_RST));
        check("rst_sq_flush_cnt", 32'(flush_events), 0);
        idle_in(); cyc(); rst_ = 1;
        cyc();
        check("rst_sq_release", 32'(outs), 32'(O_IDLE));

        // Reset during MEM_WAIT
        mem_busy = 1;
        cyc(); cyc();
        rst_ = 0; #1;
        check("rst_mw_outs", 32'(outs), 32'(O_RST));
        check("rst_mw_stall_cnt", 32'(stall_cycles), 0);
        idle_in(); cyc(); rst_ = 1;
        cyc();
        check("rst_mw_release", 32'(outs), 32'(O_IDLE));
        check("rst_mw_cnt_hold", 32'(stall_cycles), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
